// File: rtl/writeback_regfile_if.sv
// Shared writeback types and the pipeline-side bundle of writeback_regfile:
// stage input with its advance strobe, plus the retirement report.
package writeback_regfile_pkg;

  typedef enum logic [2:0] {
    RD_SEL_ALU  = 3'd0,
    RD_SEL_MEM  = 3'd1,
    RD_SEL_PC4  = 3'd2,
    RD_SEL_UIMM = 3'd3
  } rd_sel_e;

  typedef struct packed {
    logic    regf_we;
    rd_sel_e rd_sel;
  } control_wb_t;

endpackage

interface writeback_regfile_if
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned ORDER_W = 64
);

  typedef struct packed {
    logic               valid;
    logic [ORDER_W-1:0] order;
    logic [31:0]        pc;
    logic [31:0]        u_imm;
    logic [31:0]        alu_out;
    logic [31:0]        load_type;
    logic [4:0]         rd_s;
    control_wb_t        control_wb;
  } mem_wb_stage_reg_t;

  logic               go;
  mem_wb_stage_reg_t  mem_wb_stage_reg;
  logic               commit_valid;
  logic [ORDER_W-1:0] commit_order;
  logic [4:0]         commit_rd;
  logic [31:0]        commit_wdata;
  logic               order_err;

  modport master (
    output go, mem_wb_stage_reg,
    input  commit_valid, commit_order, commit_rd, commit_wdata, order_err
  );

  modport slave (
    input  go, mem_wb_stage_reg,
    output commit_valid, commit_order, commit_rd, commit_wdata, order_err
  );

endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage register plus 32x32 integer register file with retirement report.
// Define WB_BYPASS_EN to make a committing write visible to same-cycle reads.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned ORDER_W       = 64,
  parameter logic [31:0] REG_RESET_VAL = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  writeback_regfile_if.slave  wb,
  input  logic [4:0]          rs1_s,
  input  logic [4:0]          rs2_s,
  output logic [31:0]         rs1_v,
  output logic [31:0]         rs2_v,
  output logic                wb_fwd_valid,
  output logic [4:0]          wb_fwd_rd,
  output logic [31:0]         wb_fwd_data
);

  typedef struct packed {
    logic               valid;
    logic [ORDER_W-1:0] order;
    logic [31:0]        pc;
    logic [31:0]        u_imm;
    logic [31:0]        alu_out;
    logic [31:0]        load_type;
    logic [4:0]         rd_s;
    control_wb_t        control_wb;
  } stage_t;

  stage_t             wb_q;
  logic [31:0]        regs [32];
  logic [ORDER_W-1:0] exp_order;
  logic               order_err_q;
  logic [31:0]        wdata;
  logic               commit;
  logic               rd_nz;
  logic               wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (wb.go) begin
      wb_q <= wb.mem_wb_stage_reg;
    end
  end

  always_comb begin
    wdata = '0;
    case (wb_q.control_wb.rd_sel)
      RD_SEL_ALU:  wdata = wb_q.alu_out;
      RD_SEL_MEM:  wdata = wb_q.load_type;
      RD_SEL_PC4:  wdata = wb_q.pc + 32'd4;
      RD_SEL_UIMM: wdata = wb_q.u_imm;
      default:     wdata = '0;
    endcase
  end

  assign commit = wb_q.valid & wb.go;
  assign rd_nz  = |wb_q.rd_s;
  assign wr_en  = commit & wb_q.control_wb.regf_we & rd_nz;

  // x0 storage is never written; reads of address 0 are masked below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i[4:0]] <= REG_RESET_VAL;
      end
    end else if (wr_en) begin
      regs[wb_q.rd_s] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_order   <= '0;
      order_err_q <= 1'b0;
    end else if (commit) begin
      exp_order <= exp_order + ORDER_W'(1);
      if (wb_q.order != exp_order) begin
        order_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rs1_v = (rs1_s == 5'd0) ? '0 : regs[rs1_s];
    rs2_v = (rs2_s == 5'd0) ? '0 : regs[rs2_s];
`ifdef WB_BYPASS_EN
    if (wr_en && (rs1_s == wb_q.rd_s)) rs1_v = wdata;
    if (wr_en && (rs2_s == wb_q.rd_s)) rs2_v = wdata;
`endif
  end

  assign wb_fwd_valid    = wb_q.valid & wb_q.control_wb.regf_we & rd_nz;
  assign wb_fwd_rd       = wb_q.rd_s;
  assign wb_fwd_data     = wdata;

  assign wb.commit_valid = commit;
  assign wb.commit_order = wb_q.order;
  assign wb.commit_rd    = wb_q.control_wb.regf_we ? wb_q.rd_s : '0;
  assign wb.commit_wdata = (wb_q.control_wb.regf_we & rd_nz) ? wdata : '0;
  assign wb.order_err    = order_err_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: expected retirements are queued as
// entries enter the stage and popped when commit_valid appears.
module tb_writeback_regfile;
  import writeback_regfile_pkg::*;

  // Narrow order width so the commit counter wraps within the random phase.
  localparam int unsigned OW      = 4;
  localparam logic [31:0] RST_VAL = 32'h1357_9BDF;

  typedef struct packed {
    logic          valid;
    logic [OW-1:0] order;
    logic [31:0]   pc;
    logic [31:0]   u_imm;
    logic [31:0]   alu_out;
    logic [31:0]   load_type;
    logic [4:0]    rd_s;
    control_wb_t   control_wb;
  } stage_t;

  typedef struct {
    logic [OW-1:0] order;
    logic [4:0]    rd;
    logic [31:0]   wdata;
  } exp_t;

  localparam stage_t BUBBLE = '0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1_s = '0;
  logic [4:0]  rs2_s = '0;
  logic [31:0] rs1_v, rs2_v;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;

  writeback_regfile_if #(.ORDER_W(OW)) wbif ();

  writeback_regfile #(.ORDER_W(OW), .REG_RESET_VAL(RST_VAL)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (wbif),
    .rs1_s        (rs1_s),
    .rs2_s        (rs2_s),
    .rs1_v        (rs1_v),
    .rs2_v        (rs2_v),
    .wb_fwd_valid (wb_fwd_valid),
    .wb_fwd_rd    (wb_fwd_rd),
    .wb_fwd_data  (wb_fwd_data)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0]   mregs [32];
  logic [OW-1:0] m_exp;
  logic          m_err;
  stage_t        m_wb;
  exp_t          sb [$];
  logic [OW-1:0] next_order;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_wdata(input stage_t s);
    case (s.control_wb.rd_sel)
      RD_SEL_ALU:  return s.alu_out;
      RD_SEL_MEM:  return s.load_type;
      RD_SEL_PC4:  return s.pc + 32'd4;
      RD_SEL_UIMM: return s.u_imm;
      default:     return 32'h0;
    endcase
  endfunction

  // Each source field carries a distinct value so a wrong select is visible.
  function automatic stage_t mk(input logic [OW-1:0] ord, input logic [4:0] rd,
                                input logic we, input rd_sel_e sel, input logic [31:0] data);
    stage_t s;
    s.valid              = 1'b1;
    s.order              = ord;
    s.pc                 = data;
    s.u_imm              = {data[15:0], data[31:16]};
    s.alu_out            = data;
    s.load_type          = ~data;
    s.rd_s               = rd;
    s.control_wb.regf_we = we;
    s.control_wb.rd_sel  = sel;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = RST_VAL;
    m_exp      = '0;
    m_err      = 1'b0;
    m_wb       = '0;
    next_order = '0;
    sb.delete();
  endtask

  task automatic cycle(input logic g, input stage_t e, input logic [4:0] a1, input logic [4:0] a2);
    exp_t        x;
    logic        wr;
    logic [31:0] r1, r2;
    @(negedge clk);
    wbif.go               = g;
    wbif.mem_wb_stage_reg = e;
    rs1_s                 = a1;
    rs2_s                 = a2;
    if (g && e.valid) begin
      x.order = e.order;
      x.rd    = e.control_wb.regf_we ? e.rd_s : 5'd0;
      x.wdata = (e.control_wb.regf_we && e.rd_s != 0) ? model_wdata(e) : 32'h0;
      sb.push_back(x);
    end
    #1;
    wr = m_wb.valid && g && m_wb.control_wb.regf_we && (m_wb.rd_s != 0);
    check_eq("commit_valid", wbif.commit_valid, m_wb.valid && g);
    if (wbif.commit_valid) begin
      check_eq("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check_eq("commit_order", wbif.commit_order, x.order);
        check_eq("commit_rd", wbif.commit_rd, x.rd);
        check_eq("commit_wdata", wbif.commit_wdata, x.wdata);
      end
    end
    check_eq("fwd_valid", wb_fwd_valid, m_wb.valid && m_wb.control_wb.regf_we && (m_wb.rd_s != 0));
    if (m_wb.valid && m_wb.control_wb.regf_we && (m_wb.rd_s != 0)) begin
      check_eq("fwd_rd", wb_fwd_rd, m_wb.rd_s);
      check_eq("fwd_data", wb_fwd_data, model_wdata(m_wb));
    end
    r1 = (a1 == 0) ? 32'h0 : mregs[a1];
    r2 = (a2 == 0) ? 32'h0 : mregs[a2];
`ifdef WB_BYPASS_EN
    if (wr && a1 == m_wb.rd_s) r1 = model_wdata(m_wb);
    if (wr && a2 == m_wb.rd_s) r2 = model_wdata(m_wb);
`endif
    check_eq("rs1_v", rs1_v, r1);
    check_eq("rs2_v", rs2_v, r2);
    check_eq("order_err", wbif.order_err, m_err);
    if (m_wb.valid && g) begin
      if (wr) mregs[m_wb.rd_s] = model_wdata(m_wb);
      if (m_wb.order != m_exp) m_err = 1'b1;
      m_exp = m_exp + 1'b1;
    end
    if (g) m_wb = e;
  endtask

  task automatic push_entry(input logic [4:0] rd, input logic we, input rd_sel_e sel,
                            input logic [31:0] data, input logic [4:0] a1, input logic [4:0] a2);
    cycle(1'b1, mk(next_order, rd, we, sel, data), a1, a2);
    next_order = next_order + 1'b1;
  endtask

  initial begin
    stage_t e;
    logic   g;
    wbif.go               = 1'b0;
    wbif.mem_wb_stage_reg = BUBBLE;
    rs1_s                 = 5'd5;
    rs2_s                 = 5'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_commit_valid", wbif.commit_valid, 0);
    check_eq("rst_fwd_valid", wb_fwd_valid, 0);
    check_eq("rst_commit_order", wbif.commit_order, 0);
    check_eq("rst_commit_rd", wbif.commit_rd, 0);
    check_eq("rst_commit_wdata", wbif.commit_wdata, 0);
    check_eq("rst_order_err", wbif.order_err, 0);
    check_eq("rst_x5", rs1_v, RST_VAL);
    check_eq("rst_x0", rs2_v, 0);
    @(negedge clk);
    rst = 1'b1;

    // basic write then read back
    push_entry(5'd5, 1'b1, RD_SEL_ALU, 32'hDEAD_BEEF, 5'd0, 5'd0);
    cycle(1'b1, BUBBLE, 5'd5, 5'd0);
    cycle(1'b1, BUBBLE, 5'd5, 5'd0);

    // x0 write is discarded and not forwarded
    push_entry(5'd0, 1'b1, RD_SEL_ALU, 32'h0000_1234, 5'd0, 5'd0);
    cycle(1'b1, BUBBLE, 5'd0, 5'd0);
    cycle(1'b1, BUBBLE, 5'd1, 5'd0);

    // three stalled cycles, then a single commit
    push_entry(5'd9, 1'b1, RD_SEL_UIMM, 32'h1234_5000, 5'd0, 5'd0);
    repeat (3) cycle(1'b0, BUBBLE, 5'd9, 5'd0);
    cycle(1'b1, BUBBLE, 5'd9, 5'd0);
    cycle(1'b1, BUBBLE, 5'd9, 5'd9);

    // same-cycle read of the register being written
    push_entry(5'd7, 1'b1, RD_SEL_ALU, 32'hA5A5_A5A5, 5'd0, 5'd0);
    cycle(1'b1, BUBBLE, 5'd7, 5'd7);
    cycle(1'b1, BUBBLE, 5'd7, 5'd0);

    // back-to-back: pc+4 wrap, load data, unknown select, no-write entry
    push_entry(5'd10, 1'b1, RD_SEL_PC4, 32'hFFFF_FFFC, 5'd0, 5'd0);
    push_entry(5'd11, 1'b1, RD_SEL_MEM, 32'h0F0F_1234, 5'd10, 5'd0);
    push_entry(5'd12, 1'b1, rd_sel_e'(3'd6), 32'h7777_8888, 5'd10, 5'd11);
    push_entry(5'd13, 1'b0, RD_SEL_ALU, 32'h4444_5555, 5'd11, 5'd12);
    cycle(1'b1, BUBBLE, 5'd10, 5'd11);
    cycle(1'b1, BUBBLE, 5'd12, 5'd13);

    // random traffic with stalls and bubbles; order stays sequential and wraps
    for (int i = 0; i < 80; i++) begin
      g = ($urandom_range(0, 3) != 0);
      e = mk(next_order, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             rd_sel_e'(3'($urandom_range(0, 7))), $urandom);
      e.valid = 1'($urandom_range(0, 2) != 0);
      cycle(g, e, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (g && e.valid) next_order = next_order + 1'b1;
    end
    cycle(1'b1, BUBBLE, 5'd1, 5'd2);
    cycle(1'b1, BUBBLE, 5'd3, 5'd4);

    // reset while a valid entry is about to commit
    push_entry(5'd5, 1'b1, RD_SEL_ALU, 32'hCAFE_F00D, 5'd0, 5'd0);
    @(negedge clk);
    wbif.go               = 1'b1;
    wbif.mem_wb_stage_reg = BUBBLE;
    rs1_s                 = 5'd5;
    #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_commit_valid", wbif.commit_valid, 0);
    check_eq("mid_rst_fwd_valid", wb_fwd_valid, 0);
    check_eq("mid_rst_commit_order", wbif.commit_order, 0);
    check_eq("mid_rst_commit_rd", wbif.commit_rd, 0);
    check_eq("mid_rst_commit_wdata", wbif.commit_wdata, 0);
    check_eq("mid_rst_order_err", wbif.order_err, 0);
    check_eq("mid_rst_x5", rs1_v, RST_VAL);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, BUBBLE, 5'd5, 5'd7);

    // order sequence 0,1,3: error flag rises on the third commit and sticks
    push_entry(5'd20, 1'b1, RD_SEL_ALU, 32'h0000_0020, 5'd0, 5'd0);
    push_entry(5'd21, 1'b1, RD_SEL_ALU, 32'h0000_0021, 5'd20, 5'd0);
    next_order = next_order + 1'b1;
    push_entry(5'd22, 1'b1, RD_SEL_ALU, 32'h0000_0022, 5'd21, 5'd0);
    cycle(1'b1, BUBBLE, 5'd22, 5'd0);
    check_eq("order_err_set", wbif.order_err, 0);
    cycle(1'b1, BUBBLE, 5'd22, 5'd0);
    check_eq("order_err_sticky", wbif.order_err, 1);
    repeat (2) cycle(1'b0, BUBBLE, 5'd20, 5'd21);
    check_eq("order_err_held", wbif.order_err, 1);

    check_eq("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have parameter ORDER_W, default 64, width of commit order counter and compared order field.
REQ-002 SHALL have parameter REG_RESET_VAL, default 32'h0, reset value of x1..x31.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port go  input  1  pipeline advance; 0 = global stall.
REQ-006 SHALL have port mem_wb_stage_reg  input  mem_wb_stage_reg_t  memory-stage result (valid, order, pc, u_imm, alu_out, load_type, rd_s, control_wb).
REQ-007 SHALL have ports rs1_s, rs2_s  input  5 each  decode-stage read addresses.
REQ-008 SHALL have ports rs1_v, rs2_v  output  32 each  read data.
REQ-009 SHALL have ports wb_fwd_valid  output  1, wb_fwd_rd  output  5, wb_fwd_data  output  32  forwarding source to execute.
REQ-010 SHALL have ports commit_valid  output  1, commit_order  output  ORDER_W, commit_rd  output  5, commit_wdata  output  32  retirement report.
REQ-011 SHALL have port order_err  output  1  sticky order-mismatch flag.

Function
REQ-012 SHALL contain a writeback register (wb_q) loaded from mem_wb_stage_reg on every rising edge with go=1 and held unchanged when go=0.
REQ-013 SHALL compute wdata from wb_q.control_wb.rd_sel: rd_sel_alu -> alu_out; rd_sel_mem -> load_type; rd_sel_pc4 -> pc+4 (mod 2^32); rd_sel_uimm -> u_imm; any other encoding -> 32'h0.
REQ-014 SHALL define commit = wb_q.valid AND go.
REQ-015 SHALL write wdata to register wb_q.rd_s on the rising edge where commit=1, control_wb.regf_we=1 and rd_s!=0; no other edge modifies the file.
REQ-016 SHALL return 0 for any read of x0; writes to x0 discarded.
REQ-017 SHALL drive rs1_v/rs2_v combinationally from the register file (zero-cycle read latency).
REQ-018 SHALL drive wb_fwd_valid = wb_q.valid AND regf_we AND rd_s!=0, independent of go; wb_fwd_rd = wb_q.rd_s; wb_fwd_data = wdata.
REQ-019 SHALL drive commit_valid = commit combinationally, with commit_order = wb_q.order, commit_rd = rd_s if regf_we else 0, commit_wdata = wdata if regf_we and rd_s!=0 else 0.
REQ-020 SHALL hold internal counter exp_order, incremented by 1 on each commit, wrapping modulo 2^ORDER_W.
REQ-021 SHALL set order_err on a commit where wb_q.order != exp_order; cleared only by reset.
REQ-022 SHALL, on go=0, produce no write, no commit_valid and no counter change, regardless of wb_q.valid.
REQ-023 SHALL treat invalid (bubble) wb_q entries as no-ops: no write, no commit, no counter change.

Reset
REQ-024 SHALL, while rst=0, asynchronously force wb_q.valid=0, all other wb_q fields 0, x1..x31=REG_RESET_VAL, exp_order=0, order_err=0.
REQ-025 SHALL hold commit_valid=0, wb_fwd_valid=0, commit_order=0, commit_rd=0, commit_wdata=0 during reset; reset mid-commit discards the pending write.

Configuration
REQ-026 SHALL implement write-through bypass only when WB_BYPASS_EN is defined: a read whose address equals wb_q.rd_s (nonzero) while a write commits in that cycle returns wdata.
REQ-027 SHALL, without WB_BYPASS_EN, return the pre-write register value in that case; the new value is visible from the next cycle.

Verification
REQ-028 SHALL cover reset: rst=0 mid-stream with valid entry loaded -> all outputs 0, x5 reads REG_RESET_VAL, order_err=0.
REQ-029 SHALL cover write/read: commit rd=5, rd_sel_alu, alu_out=32'hDEADBEEF -> next cycle rs1_s=5 gives 32'hDEADBEEF, commit_order=0.
REQ-030 SHALL cover x0: commit rd=0, regf_we=1, alu_out=32'h1234 -> rs2_s=0 reads 0, commit_rd=0, wb_fwd_valid=0.
REQ-031 SHALL cover stall: valid entry with go=0 for 3 cycles -> no commit_valid, register unchanged, exp_order unchanged; go=1 -> single commit.
REQ-032 SHALL cover bypass: commit rd=7 wdata=32'hA5A5A5A5 with rs1_s=7 same cycle -> 32'hA5A5A5A5 if WB_BYPASS_EN, else old value 0.
REQ-033 SHALL cover order check: commits with order 0,1,3 -> order_err rises on third commit and stays 1; rd_sel_pc4 with pc=32'hFFFFFFFC writes 0.
